// File: rtl/asyn_pipe_fifo_n_pkg.sv
// Shared types for the N-stage req/ack handshake pipeline: FSM state enums
// and the occupancy-counter width helper.
package asyn_pipe_pkg;

  typedef enum logic {
    IN_IDLE,
    IN_RTZ
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_RTZ
  } out_state_t;

  // Enough bits to count 0..stages full stages inclusive.
  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/asyn_pipe_fifo_n_if.sv
// Upstream and downstream four-phase handshake bundle for asyn_pipe_fifo_n.
// The pipeline takes the slave view; the environment takes the master view.
interface asyn_pipe_fifo_n_if
  import asyn_pipe_pkg::*;
#(
  parameter int DATA_W = 3
);

  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;

  modport master (
    output req_in,
    output data_in,
    output ack_in,
    input  ack_out,
    input  req_out,
    input  data_out
  );

  modport slave (
    input  req_in,
    input  data_in,
    input  ack_in,
    output ack_out,
    output req_out,
    output data_out
  );

endinterface

// File: rtl/asyn_pipe_fifo_n_stage.sv
// One storage slot of the pipeline: a full flag plus a payload register.
// A load on the same edge as a clear wins, so a slot can hand off and refill at once.
module asyn_pipe_stage
  import asyn_pipe_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              full,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/asyn_pipe_fifo_n.sv
// Parametrised STAGES-deep, DATA_W-wide four-phase handshake pipeline on one clock.
// Define ASYN_PIPE_OCC_EN to add the registered full-stage count port 'occ'.
module asyn_pipe_fifo_n
  import asyn_pipe_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  asyn_pipe_fifo_n_if.slave        bus
`ifdef ASYN_PIPE_OCC_EN
  ,
  output logic [occ_w(STAGES)-1:0] occ
`endif
);

  logic [STAGES-1:0] full;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] clear;
  logic [DATA_W-1:0] stage_d [STAGES];
  logic [DATA_W-1:0] stage_q [STAGES];

  logic capture;
  logic emit;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  // A stage empties when its item leaves: the last one on emit, the others
  // when the next stage is free or freeing on the same edge.
  always_comb begin
    clear = '0;
    clear[STAGES-1] = emit;
    for (int i = STAGES - 2; i >= 0; i--) begin
      clear[i] = full[i] & (~full[i+1] | clear[i+1]);
    end
  end

  always_comb begin
    load = '0;
    load[0] = capture;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = clear[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_d[g] = bus.data_in;
    end else begin : g_next
      assign stage_d[g] = stage_q[g-1];
    end

    asyn_pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (load[g]),
      .clear(clear[g]),
      .d    (stage_d[g]),
      .full (full[g]),
      .q    (stage_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state <= IN_IDLE;
    end else begin
      in_state <= in_next;
    end
  end

  always_comb begin
    in_next = in_state;
    capture = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (bus.req_in && (!full[0] || clear[0])) begin
          capture = 1'b1;
          in_next = IN_RTZ;
        end
      end
      IN_RTZ: begin
        if (!bus.req_in) begin
          in_next = IN_IDLE;
        end
      end
      default: in_next = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state <= OUT_IDLE;
    end else begin
      out_state <= out_next;
    end
  end

  // The last stage is freed exactly when the downstream ack is seen in OUT_REQ.
  always_comb begin
    out_next = out_state;
    emit     = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (full[STAGES-1]) begin
          out_next = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (bus.ack_in) begin
          emit     = 1'b1;
          out_next = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!bus.ack_in) begin
          out_next = OUT_IDLE;
        end
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  assign bus.ack_out  = (in_state == IN_RTZ);
  assign bus.req_out  = (out_state == OUT_REQ);
  assign bus.data_out = stage_q[STAGES-1];

`ifdef ASYN_PIPE_OCC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
    end else if (capture && !emit) begin
      occ <= occ + 1'b1;
    end else if (emit && !capture) begin
      occ <= occ - 1'b1;
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!rst)
    int'(occ) <= STAGES);
`endif

  a_req_has_item: assert property (@(posedge clk) disable iff (!rst)
    bus.req_out |-> full[STAGES-1]);

  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst)
    (load & full & ~clear) == '0);

endmodule

// File: tb/tb_asyn_pipe_fifo_n.sv
// Bench for asyn_pipe_fifo_n: a 3x3 instance and a 1-stage 8-bit instance,
// each shadowed by a queue model of the items in flight.
`timescale 1ns/1ps
module tb_asyn_pipe_fifo_n;

  localparam int S_A = 3;
  localparam int W_A = 3;
  localparam int S_B = 1;
  localparam int W_B = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  asyn_pipe_fifo_n_if #(.DATA_W(W_A)) a_if ();
  asyn_pipe_fifo_n_if #(.DATA_W(W_B)) b_if ();

`ifdef ASYN_PIPE_OCC_EN
  logic [$clog2(S_A+1)-1:0] occ_a;
  logic [$clog2(S_B+1)-1:0] occ_b;
`endif

  asyn_pipe_fifo_n #(.DATA_W(W_A), .STAGES(S_A)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if.slave)
`ifdef ASYN_PIPE_OCC_EN
    ,
    .occ(occ_a)
`endif
  );

  asyn_pipe_fifo_n #(.DATA_W(W_B), .STAGES(S_B)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if.slave)
`ifdef ASYN_PIPE_OCC_EN
    ,
    .occ(occ_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Downstream responders: A echoes req_out when enabled, B acks after delay_b cycles.
  bit auto_a = 1'b0;
  int delay_b = 0;
  int wait_b = 0;

  always @(negedge clk) a_if.ack_in = auto_a ? a_if.req_out : 1'b0;

  always @(negedge clk) begin
    if (!b_if.req_out) begin
      b_if.ack_in = 1'b0;
      wait_b = 0;
    end else if (wait_b >= delay_b) begin
      b_if.ack_in = 1'b1;
    end else begin
      wait_b++;
    end
  end

  logic [W_A-1:0] din_a_e;
  logic           ack_a_e;
  logic [W_B-1:0] din_b_e;
  logic           ack_b_e;

  always @(posedge clk) begin
    din_a_e = a_if.data_in;
    ack_a_e = a_if.ack_in;
    din_b_e = b_if.data_in;
    ack_b_e = b_if.ack_in;
  end

  // Model: items enter on an ack_out rise, leave on a req_out fall, in order,
  // never more than STAGES at once; data_out shows the oldest while req_out is high.
  logic [W_A-1:0] q_a[$];
  logic [W_A-1:0] rcv_a[$];
  logic           prev_ack_a = 1'b0, prev_req_a = 1'b0;
  logic [W_A-1:0] last_out_a = '0;
  logic           cap_a, emt_a;

  always @(negedge clk) begin
    if (!rst) begin
      q_a.delete();
      prev_ack_a = 1'b0;
      prev_req_a = 1'b0;
    end else begin
      cap_a = a_if.ack_out && !prev_ack_a;
      emt_a = !a_if.req_out && prev_req_a;
      if (emt_a) begin
        check_output("a_emit_after_ack", ack_a_e, 1);
        rcv_a.push_back(last_out_a);
        if (q_a.size() > 0) void'(q_a.pop_front());
      end
      if (cap_a) begin
        check_output("a_capture_room", q_a.size() < S_A, 1);
        q_a.push_back(din_a_e);
      end
      if (a_if.req_out) begin
        check_output("a_req_has_item", q_a.size() > 0, 1);
        if (q_a.size() > 0) check_output("a_data_out", a_if.data_out, q_a[0]);
        last_out_a = a_if.data_out;
      end
`ifdef ASYN_PIPE_OCC_EN
      check_output("a_occ", occ_a, q_a.size());
`endif
      prev_ack_a = a_if.ack_out;
      prev_req_a = a_if.req_out;
    end
  end

  logic [W_B-1:0] q_b[$];
  logic [W_B-1:0] rcv_b[$];
  logic           prev_ack_b = 1'b0, prev_req_b = 1'b0;
  logic [W_B-1:0] last_out_b = '0;
  logic           cap_b, emt_b;

  always @(negedge clk) begin
    if (!rst) begin
      q_b.delete();
      prev_ack_b = 1'b0;
      prev_req_b = 1'b0;
    end else begin
      cap_b = b_if.ack_out && !prev_ack_b;
      emt_b = !b_if.req_out && prev_req_b;
      if (emt_b) begin
        check_output("b_emit_after_ack", ack_b_e, 1);
        rcv_b.push_back(last_out_b);
        if (q_b.size() > 0) void'(q_b.pop_front());
      end
      if (cap_b) begin
        check_output("b_capture_room", q_b.size() < S_B, 1);
        q_b.push_back(din_b_e);
      end
      if (b_if.req_out) begin
        check_output("b_req_has_item", q_b.size() > 0, 1);
        if (q_b.size() > 0) check_output("b_data_out", b_if.data_out, q_b[0]);
        last_out_b = b_if.data_out;
      end
`ifdef ASYN_PIPE_OCC_EN
      check_output("b_occ", occ_b, q_b.size());
`endif
      prev_ack_b = b_if.ack_out;
      prev_req_b = b_if.req_out;
    end
  end

  function automatic logic [31:0] rcv_a_at(input int i);
    if (i < rcv_a.size()) return 32'(rcv_a[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rcv_b_at(input int i);
    if (i < rcv_b.size()) return 32'(rcv_b[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack_a(input logic v, input int budget);
    int k = 0;
    while (a_if.ack_out !== v && k < budget) begin
      tick();
      k++;
    end
    check_output("a_ack_wait", a_if.ack_out, v);
  endtask

  task automatic wait_ack_b(input logic v, input int budget);
    int k = 0;
    while (b_if.ack_out !== v && k < budget) begin
      tick();
      k++;
    end
    check_output("b_ack_wait", b_if.ack_out, v);
  endtask

  task automatic wait_rcv_a(input int n, input int budget);
    int k = 0;
    while (rcv_a.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output("a_rcv_count", rcv_a.size(), n);
  endtask

  task automatic wait_rcv_b(input int n, input int budget);
    int k = 0;
    while (rcv_b.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output("b_rcv_count", rcv_b.size(), n);
  endtask

  task automatic send_a(input logic [W_A-1:0] v);
    a_if.req_in  = 1'b1;
    a_if.data_in = v;
    wait_ack_a(1'b1, 40);
    a_if.req_in = 1'b0;
    wait_ack_a(1'b0, 40);
  endtask

  int lat;

  initial begin
    rst = 1'b0;
    a_if.req_in  = 1'b1;
    a_if.data_in = 3'd6;
    b_if.req_in  = 1'b0;
    b_if.data_in = '0;
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] reset state");
    check_output("a_rst_ack_out", a_if.ack_out, 0);
    check_output("a_rst_req_out", a_if.req_out, 0);
    check_output("a_rst_data_out", a_if.data_out, 0);
    check_output("b_rst_req_out", b_if.req_out, 0);
    check_output("b_rst_data_out", b_if.data_out, 0);
`ifdef ASYN_PIPE_OCC_EN
    check_output("a_rst_occ", occ_a, 0);
`endif

    // req_in held through reset is taken on the first edge afterwards.
    rst = 1'b1;
    tick();
    check_output("a_first_edge_capture", a_if.ack_out, 1);
    a_if.req_in = 1'b0;
    auto_a = 1'b1;
    wait_rcv_a(1, 20);
    check_output("a_first_item", rcv_a_at(0), 6);
    repeat (3) tick();

    $display("[TB] single item");
    rcv_a.delete();
    a_if.req_in  = 1'b1;
    a_if.data_in = 3'd1;
    wait_ack_a(1'b1, 10);
    a_if.req_in = 1'b0;
    lat = 0;
    while (!a_if.req_out && lat < 20) begin
      tick();
      lat++;
    end
    check_output("a_latency", lat, 3);
    check_output("a_single_data", a_if.data_out, 1);
    check_output("a_ack_returned", a_if.ack_out, 0);
    wait_rcv_a(1, 20);
    repeat (2) tick();
    check_output("a_req_returned", a_if.req_out, 0);
    check_output("a_single_rcv", rcv_a_at(0), 1);

    $display("[TB] backpressure");
    auto_a = 1'b0;
    repeat (2) tick();
    rcv_a.delete();
    send_a(3'd1);
    send_a(3'd2);
    send_a(3'd3);
    a_if.req_in  = 1'b1;
    a_if.data_in = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("a_full_no_ack", a_if.ack_out, 0);
      check_output("a_stable_req", a_if.req_out, 1);
      check_output("a_stable_data", a_if.data_out, 1);
    end
`ifdef ASYN_PIPE_OCC_EN
    check_output("a_full_occ", occ_a, 3);
`endif
    auto_a = 1'b1;
    wait_ack_a(1'b1, 20);
    a_if.req_in = 1'b0;
    wait_ack_a(1'b0, 20);
    wait_rcv_a(4, 60);
    for (int i = 0; i < 4; i++) begin
      check_output("a_order", rcv_a_at(i), i + 1);
    end
    repeat (3) tick();

    $display("[TB] reset mid-flow");
    auto_a = 1'b0;
    repeat (2) tick();
    rcv_a.delete();
    send_a(3'd2);
    send_a(3'd3);
    #1 rst = 1'b0;
    #1;
    check_output("a_midrst_ack_out", a_if.ack_out, 0);
    check_output("a_midrst_req_out", a_if.req_out, 0);
    check_output("a_midrst_data_out", a_if.data_out, 0);
`ifdef ASYN_PIPE_OCC_EN
    check_output("a_midrst_occ", occ_a, 0);
`endif
    tick();
    rst = 1'b1;
    auto_a = 1'b1;
    send_a(3'd5);
    wait_rcv_a(1, 30);
    repeat (6) tick();
    check_output("a_after_rst_count", rcv_a.size(), 1);
    check_output("a_after_rst_item", rcv_a_at(0), 5);

    $display("[TB] one-stage 8-bit pipe");
    delay_b = 3;
    rcv_b.delete();
    b_if.req_in  = 1'b1;
    b_if.data_in = 8'hA5;
    wait_ack_b(1'b1, 10);
    b_if.req_in = 1'b0;
    lat = 0;
    while (!b_if.req_out && lat < 10) begin
      tick();
      lat++;
    end
    check_output("b_latency", lat, 1);
    check_output("b_data_a5", b_if.data_out, 8'hA5);
    b_if.req_in  = 1'b1;
    b_if.data_in = 8'h5A;
    wait_ack_b(1'b1, 20);
    b_if.req_in = 1'b0;
    delay_b = 0;
    wait_ack_b(1'b0, 20);
    wait_rcv_b(2, 40);
    check_output("b_first", rcv_b_at(0), 8'hA5);
    check_output("b_second", rcv_b_at(1), 8'h5A);
    repeat (3) tick();
    check_output("b_idle_req", b_if.req_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
